// File: rtl/rx_deser_pkg.sv
// Shared constants and types for the rx_word_deser receive deserializer.
package rx_deser_pkg;

  localparam int STUFF_RUN    = 6;
  localparam int SE_DELAY_MAX = 7;

  typedef logic [SE_DELAY_MAX-1:0] se_pipe_t;

  function automatic int count_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/rx_word_deser_se_delay_line.sv
// Delays the shift strobe by SE_DELAY clocks; flush empties the chain.
module se_delay_line
  import rx_deser_pkg::*;
#(
  parameter int SE_DELAY = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  localparam int       OUT_IDX    = (SE_DELAY == 0) ? 0 : SE_DELAY - 1;
  localparam se_pipe_t STAGE_MASK = se_pipe_t'((1 << SE_DELAY) - 1);
  localparam se_pipe_t OUT_MASK   = se_pipe_t'(1) << OUT_IDX;

  se_pipe_t pipe_reg;
  se_pipe_t pipe_next;

  // Stages beyond SE_DELAY are masked so they stay zero.
  always_comb begin
    pipe_next = {pipe_reg[SE_DELAY_MAX-2:0], din} & STAGE_MASK;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pipe_reg <= '0;
    end else if (flush) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  generate
    if (SE_DELAY == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      assign dout = |(pipe_reg & OUT_MASK);
    end
  endgenerate

endmodule

// File: rtl/rx_word_deser.sv
// Serial-to-parallel receive deserializer with valid/ready holding register.
// Optional bit unstuffing is enabled by defining RX_DESER_BIT_UNSTUFF_EN.
module rx_word_deser
  import rx_deser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SE_DELAY  = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       shift_enable,
  input  logic                       d_orig,
  input  logic                       clear,
  input  logic                       rcv_ready,
  output logic [DATA_W-1:0]          rcv_data,
  output logic                       rcv_valid,
  output logic                       overrun,
  output logic [count_w(DATA_W)-1:0] bit_count,
  output logic                       stuff_err
);

  localparam int            CW       = count_w(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic              se_d;
  logic              take_bit;
  logic              shift_fire;
  logic              complete;
  logic              xfer;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-2:0] partial_reg;
  logic [DATA_W-2:0] partial_next;
  logic [CW-1:0]     bit_count_reg;
  logic [DATA_W-1:0] rcv_data_reg;
  logic              rcv_valid_reg;
  logic              overrun_reg;

  se_delay_line #(
    .SE_DELAY(SE_DELAY)
  ) u_se_delay (
    .clk  (clk),
    .n_rst(n_rst),
    .flush(clear),
    .din  (shift_enable),
    .dout (se_d)
  );

`ifdef RX_DESER_BIT_UNSTUFF_EN
  logic [2:0] run_reg;
  logic       stuff_err_reg;
  logic       drop;

  assign drop     = se_d && (run_reg == 3'(STUFF_RUN));
  assign take_bit = se_d && !drop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_reg       <= '0;
      stuff_err_reg <= 1'b0;
    end else if (clear) begin
      run_reg       <= '0;
      stuff_err_reg <= 1'b0;
    end else begin
      stuff_err_reg <= drop && d_orig;
      if (se_d) begin
        run_reg <= (drop || !d_orig) ? 3'd0 : run_reg + 3'd1;
      end
    end
  end

  assign stuff_err = stuff_err_reg;
`else
  assign take_bit  = se_d;
  assign stuff_err = 1'b0;
`endif

  // The oldest bit leaves the register on the completing shift, so only
  // DATA_W-1 bits of history are ever needed.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign word_next = {d_orig, partial_reg};
      assign partial_next = word_next[DATA_W-1:1];
    end else begin : g_msb_first
      assign word_next = {partial_reg, d_orig};
      assign partial_next = word_next[DATA_W-2:0];
    end
  endgenerate

  assign shift_fire = take_bit && !clear;
  assign complete   = shift_fire && (bit_count_reg == LAST_BIT);
  assign xfer       = rcv_valid_reg && rcv_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      partial_reg   <= '1;
      bit_count_reg <= '0;
    end else if (clear) begin
      partial_reg   <= '1;
      bit_count_reg <= '0;
    end else if (shift_fire) begin
      partial_reg   <= partial_next;
      bit_count_reg <= complete ? '0 : bit_count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rcv_data_reg  <= '0;
      rcv_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (complete) begin
        rcv_data_reg  <= word_next;
        rcv_valid_reg <= 1'b1;
        if (rcv_valid_reg && !rcv_ready) begin
          overrun_reg <= 1'b1;
        end
      end else if (xfer) begin
        rcv_valid_reg <= 1'b0;
      end
      if (clear) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign rcv_data  = rcv_data_reg;
  assign rcv_valid = rcv_valid_reg;
  assign overrun   = overrun_reg;
  assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_rx_word_deser.sv
// Bench for rx_word_deser: LSB-first and MSB-first instances against a bit-list reference model.
module tb_rx_word_deser;

  localparam int DATA_W   = 8;
  localparam int SE_DELAY = 2;
  localparam int CW       = $clog2(DATA_W);

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic shift_enable = 1'b0;
  logic d_orig = 1'b0;
  logic clear = 1'b0;
  logic rcv_ready = 1'b0;

  logic [DATA_W-1:0] data_l, data_m;
  logic              valid_l, valid_m, ovr_l, ovr_m, stuff_l, stuff_m;
  logic [CW-1:0]     cnt_l, cnt_m;

  rx_word_deser #(.DATA_W(DATA_W), .SE_DELAY(SE_DELAY), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .d_orig(d_orig),
    .clear(clear), .rcv_ready(rcv_ready), .rcv_data(data_l), .rcv_valid(valid_l),
    .overrun(ovr_l), .bit_count(cnt_l), .stuff_err(stuff_l)
  );

  rx_word_deser #(.DATA_W(DATA_W), .SE_DELAY(SE_DELAY), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .d_orig(d_orig),
    .clear(clear), .rcv_ready(rcv_ready), .rcv_data(data_m), .rcv_valid(valid_m),
    .overrun(ovr_m), .bit_count(cnt_m), .stuff_err(stuff_m)
  );

  always #5 clk = ~clk;

  // Reference model: a list of accepted bits, plus a short history of
  // strobes and clears used to decide when a strobe takes effect.
  int                m_cnt;
  int                m_run;
  bit                m_bits [DATA_W];
  logic [DATA_W-1:0] m_data_l, m_data_m;
  bit                m_valid, m_ovr, m_stuff;
  bit                win_se  [SE_DELAY+1];
  bit                win_clr [SE_DELAY+1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit eff, xfer, done, take;
    if (!n_rst) begin
      m_cnt = 0; m_run = 0; m_data_l = '0; m_data_m = '0;
      m_valid = 0; m_ovr = 0; m_stuff = 0;
      for (int i = 0; i <= SE_DELAY; i++) begin
        win_se[i] = 0; win_clr[i] = 0;
      end
    end else begin
      for (int i = SE_DELAY; i > 0; i--) begin
        win_se[i]  = win_se[i-1];
        win_clr[i] = win_clr[i-1];
      end
      win_se[0]  = shift_enable;
      win_clr[0] = clear;
      eff = win_se[SE_DELAY];
      for (int i = 0; i <= SE_DELAY; i++) if (win_clr[i]) eff = 0;
      xfer    = m_valid && rcv_ready;
      m_stuff = 0;
      done    = 0;
      if (clear) begin
        m_cnt = 0; m_run = 0; m_ovr = 0;
      end else if (eff) begin
        take = 1;
`ifdef RX_DESER_BIT_UNSTUFF_EN
        if (m_run == 6) begin
          take = 0; m_run = 0; m_stuff = d_orig;
        end else begin
          m_run = d_orig ? m_run + 1 : 0;
        end
`endif
        if (take) begin
          m_bits[m_cnt] = d_orig;
          m_cnt++;
          if (m_cnt == DATA_W) begin
            done  = 1;
            m_cnt = 0;
            for (int i = 0; i < DATA_W; i++) begin
              m_data_l[i]          = m_bits[i];
              m_data_m[DATA_W-1-i] = m_bits[i];
            end
            if (m_valid && !xfer) m_ovr = 1;
            m_valid = 1;
          end
        end
      end
      if (!done && xfer) m_valid = 0;
    end
  end

  task automatic check_all();
    check_eq("data_lsb", 32'(data_l), 32'(m_data_l));
    check_eq("data_msb", 32'(data_m), 32'(m_data_m));
    check_eq("valid_lsb", 32'(valid_l), 32'(m_valid));
    check_eq("valid_msb", 32'(valid_m), 32'(m_valid));
    check_eq("overrun", 32'(ovr_l), 32'(m_ovr));
    check_eq("bit_count", 32'(cnt_l), 32'(m_cnt));
    check_eq("bit_count_msb", 32'(cnt_m), 32'(m_cnt));
    check_eq("stuff_err", 32'(stuff_l), 32'(m_stuff));
  endtask

  task automatic step(input bit se, input bit d, input bit clr, input bit rdy);
    @(negedge clk);
    check_all();
    shift_enable = se;
    d_orig       = d;
    clear        = clr;
    rcv_ready    = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 0; shift_enable = 0; d_orig = 0; clear = 0; rcv_ready = 0;
    #1;
    check_eq("rst_data", 32'(data_l), 32'h0);
    check_eq("rst_valid", 32'(valid_l), 32'h0);
    check_eq("rst_count", 32'(cnt_l), 32'h0);
    check_eq("rst_overrun", 32'(ovr_l), 32'h0);
    repeat (3) @(negedge clk);
    n_rst = 1;
  endtask

  task automatic send_bit(input bit b, input bit rdy_in_slot);
    for (int j = 0; j < 8; j++) step(j == 0, b, 0, rdy_in_slot && (j == SE_DELAY));
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input bit rdy_end);
    logic [DATA_W-1:0] wv;
    wv = w;
    for (int b = 0; b < DATA_W; b++) send_bit(wv[b], rdy_end && (b == DATA_W - 1));
    $display("word 0x%02h sent: rcv_data=0x%02h valid=%0b overrun=%0b", w, data_l, valid_l, ovr_l);
  endtask

  initial begin
    do_reset();

    send_word(8'hA5, 0);
    check_eq("a5_lsb", 32'(data_l), 32'hA5);
    check_eq("a5_msb", 32'(data_m), 32'hA5);
    check_eq("a5_valid", 32'(valid_l), 32'h1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_eq("xfer_valid", 32'(valid_l), 32'h0);

    send_word(8'h3C, 0);
    send_word(8'hC3, 0);
    check_eq("ovr_data", 32'(data_l), 32'hC3);
    check_eq("ovr_flag", 32'(ovr_l), 32'h1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("ovr_sticky", 32'(ovr_l), 32'h1);
    check_eq("ovr_consumed", 32'(valid_l), 32'h0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_eq("ovr_cleared", 32'(ovr_l), 32'h0);

    send_word(8'h11, 0);
    send_word(8'h22, 1);
    check_eq("coinc_data", 32'(data_l), 32'h22);
    check_eq("coinc_valid", 32'(valid_l), 32'h1);
    check_eq("coinc_ovr", 32'(ovr_l), 32'h0);
    step(0, 0, 0, 1);

    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (SE_DELAY + 2) step(0, 1, 0, 0);
    check_eq("clr_count", 32'(cnt_l), 32'h0);
    send_word(8'h5A, 0);
    check_eq("clr_data", 32'(data_l), 32'h5A);
    check_eq("clr_count_end", 32'(cnt_l), 32'h0);
    step(0, 0, 0, 1);

`ifdef RX_DESER_BIT_UNSTUFF_EN
    step(0, 0, 1, 0);
    repeat (6) send_bit(1, 0);
    send_bit(0, 0);
    for (int i = 0; i < 8; i++) send_bit(0, 0);
    check_eq("unstuff_data", 32'(data_l), 32'h3F);
    check_eq("unstuff_count", 32'(cnt_l), 32'h6);
    step(0, 0, 1, 1);
    repeat (7) send_bit(1, 0);
    check_eq("stuff_err_count", 32'(cnt_l), 32'h6);
    $display("stuff sequence done: bit_count=%0d", cnt_l);
`endif

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(2) == 0, $urandom_range(3) != 0,
             $urandom_range(63) == 0, $urandom_range(2) == 0);
      end
    end
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
